// File: rtl/reg_bank_serializer_pkg.sv
// Shared definitions for the register-bank unload path: stream FSM encoding
// and the default layer word geometry.
package reg_bank_serializer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } stream_state_t;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_WORDS  = 16;

endpackage

// File: rtl/reg_bank_serializer_reg_en.sv
// Generic data register with load enable and asynchronous active-high clear.
// One cycle from enabled load to output; holds its value whenever i_en is low.
module reg_en #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/reg_bank_serializer.sv
// Snapshots a flat register bank on start and streams it one word per valid/ready beat.
// First word valid one cycle after start; words hold stable under backpressure.
module reg_bank_serializer
   import reg_bank_serializer_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int NUM_WORDS  = DEF_NUM_WORDS,
   localparam int IDX_W      = $clog2(NUM_WORDS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [NUM_WORDS*DATA_WIDTH-1:0] Bank_in,
   output logic [DATA_WIDTH-1:0]           Data_out,
   output logic                            valid,
   input  logic                            ready,
   output logic                            last,
   output logic [IDX_W-1:0]                idx,
   output logic                            busy,
   output logic                            done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   stream_state_t          r_state;
   stream_state_t          w_state_nxt;
   logic [IDX_W-1:0]       r_idx;
   logic [IDX_W-1:0]       w_idx_nxt;
   logic [IDX_W-1:0]       w_idx_inc;
   logic [DATA_WIDTH-1:0]  r_data;
   logic [DATA_WIDTH-1:0]  w_data_nxt;
   logic                   r_done;
   logic                   w_done_nxt;
   logic                   w_load;
   logic [DATA_WIDTH-1:0]  w_snap [NUM_WORDS];

   genvar g;
   generate
      for (g = 0; g < NUM_WORDS; g++) begin : g_snap
         reg_en #(
            .WIDTH (DATA_WIDTH)
         ) u_word (
            .clk  (clk),
            .rst  (reset),
            .i_en (w_load),
            .i_d  (Bank_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_q  (w_snap[g])
         );
      end
   endgenerate

   assign w_idx_inc = r_idx + IDX_W'(1);

   // Word 0 is taken straight from Bank_in so it is ready the cycle after start.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_data_nxt  = r_data;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_idx_nxt   = '0;
               w_data_nxt  = Bank_in[0 +: DATA_WIDTH];
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (ready) begin
               if (r_idx == LAST_IDX) begin
                  w_state_nxt = ST_IDLE;
                  w_idx_nxt   = '0;
                  w_data_nxt  = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt  = w_idx_inc;
                  w_data_nxt = w_snap[w_idx_inc];
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_data  <= w_data_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign valid    = (r_state == ST_SEND);
   assign busy     = (r_state == ST_SEND);
   assign last     = (r_state == ST_SEND) && (r_idx == LAST_IDX);
   assign idx      = r_idx;
   assign Data_out = r_data;
   assign done     = r_done;

endmodule

// File: tb/tb_reg_bank_serializer.sv
// Directed + randomized checks of reg_bank_serializer against a word-list model.
module tb_reg_bank_serializer;

   localparam int DW = 32;
   localparam int N  = 16;
   localparam int IW = $clog2(N);

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [N*DW-1:0] Bank_in;
   logic [DW-1:0]   Data_out;
   logic            valid;
   logic            ready;
   logic            last;
   logic [IW-1:0]   idx;
   logic            busy;
   logic            done;

   int vectors    = 0;
   int miscompares = 0;

   logic [DW-1:0] bank_a [N];
   logic [DW-1:0] bank_b [N];

   reg_bank_serializer #(
      .DATA_WIDTH (DW),
      .NUM_WORDS  (N)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .Bank_in  (Bank_in),
      .Data_out (Data_out),
      .valid    (valid),
      .ready    (ready),
      .last     (last),
      .idx      (idx),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_bank(input logic [DW-1:0] b [N]);
      for (int k = 0; k < N; k++) Bank_in[k*DW +: DW] = b[k];
   endtask

   task automatic launch(input logic [DW-1:0] b [N]);
      load_bank(b);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // mode 0: ready always high, 1: ready 1,0,0,1 repeating, 2: random ready.
   // disturb: scribble Bank_in after start and re-pulse start at word 5.
   task automatic drain(input logic [DW-1:0] b [N], input int mode, input bit disturb);
      int k   = 0;
      int cyc = 0;
      bit r;
      while (k < N && cyc < N * 20) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: r = 1'($urandom_range(0, 1));
         endcase
         ready = r;
         if (disturb) begin
            Bank_in = '1;
            start   = (k == 5);
         end
         chk("valid", 64'(valid), 64'd1);
         chk("busy", 64'(busy), 64'd1);
         chk("data", 64'(Data_out), 64'(b[k]));
         chk("idx", 64'(idx), 64'(k));
         chk("last", 64'(last), 64'(k == N - 1));
         chk("done_early", 64'(done), 64'd0);
         tick();
         if (r) k++;
         cyc++;
      end
      start = 1'b0;
      ready = 1'b0;
      chk("stream_complete", 64'(k), 64'(N));
      chk("done_pulse", 64'(done), 64'd1);
      chk("valid_drop", 64'(valid), 64'd0);
      chk("busy_drop", 64'(busy), 64'd0);
      chk("last_drop", 64'(last), 64'd0);
      chk("idx_return", 64'(idx), 64'd0);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      ready   = 1'b0;
      Bank_in = '0;

      // Reset then idle
      repeat (3) tick();
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_data", 64'(Data_out), 64'd0);
      chk("rst_idx", 64'(idx), 64'd0);
      chk("rst_last", 64'(last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         ready = 1'b1;
         tick();
         chk("idle_valid", 64'(valid), 64'd0);
      end

      // Full-rate stream, then backpressure on the same bank
      for (int k = 0; k < N; k++) bank_a[k] = DW'(k + 100);
      launch(bank_a);
      drain(bank_a, 0, 1'b0);
      tick();
      chk("done_one_cycle", 64'(done), 64'd0);
      launch(bank_a);
      drain(bank_a, 1, 1'b0);
      tick();

      // Snapshot isolation and start while busy
      for (int k = 0; k < N; k++) bank_a[k] = DW'(k);
      launch(bank_a);
      drain(bank_a, 0, 1'b1);
      tick();
      chk("no_second_stream", 64'(valid), 64'd0);
      chk("single_done", 64'(done), 64'd0);

      // Back-to-back: start issued in the done cycle
      launch(bank_a);
      drain(bank_a, 0, 1'b0);
      for (int k = 0; k < N; k++) bank_b[k] = DW'(k + 200);
      load_bank(bank_b);
      start = 1'b1;
      tick();
      start = 1'b0;
      drain(bank_b, 2, 1'b0);
      tick();

      // Reset mid-operation at idx 7 under backpressure
      launch(bank_b);
      ready = 1'b1;
      repeat (7) tick();
      ready = 1'b0;
      tick();
      chk("pre_rst_idx", 64'(idx), 64'd7);
      chk("pre_rst_data", 64'(Data_out), 64'(bank_b[7]));
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", 64'(valid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_idx", 64'(idx), 64'd0);
      chk("arst_data", 64'(Data_out), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      tick();
      reset = 1'b0;
      ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("post_rst_done", 64'(done), 64'd0);
         chk("post_rst_valid", 64'(valid), 64'd0);
      end

      // Randomized banks with random backpressure
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < N; k++) bank_a[k] = $urandom;
         launch(bank_a);
         drain(bank_a, 2, 1'b0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
